// File: rtl/result_collector_if.sv
// Handshake bundle between the crypto issue/return path and the result collector.
// The slave modport is the collector's view; the master modport drives it.
interface result_collector_if #(
  parameter int RESULT_W = 16,
  parameter int OP_W     = 4,
  parameter int TAG_W    = 2,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  issue_valid;
  logic [OP_W-1:0]       issue_op;
  logic [TAG_W-1:0]      issue_tag;
  logic                  res_valid;
  logic [RESULT_W-1:0]   res_data;
  logic [TAG_W-1:0]      res_tag;
  logic                  out_valid;
  logic [RESULT_W-1:0]   out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_ready;
  logic [CNT_W-1:0]      fifo_count;
  logic [2**TAG_W-1:0]   outstanding;
  logic                  err_unexpected;
  logic                  err_overflow;
  logic                  err_dup_issue;

  modport slave (
    input  issue_valid, issue_op, issue_tag,
    input  res_valid, res_data, res_tag,
    input  out_ready,
    output out_valid, out_data, out_tag,
    output fifo_count, outstanding,
    output err_unexpected, err_overflow, err_dup_issue
  );

  modport master (
    output issue_valid, issue_op, issue_tag,
    output res_valid, res_data, res_tag,
    output out_ready,
    input  out_valid, out_data, out_tag,
    input  fifo_count, outstanding,
    input  err_unexpected, err_overflow, err_dup_issue
  );
endinterface

// File: rtl/result_collector.sv
// Tracks outstanding result-producing tags, accepts matching results into a
// FIFO in arrival order and drains it over valid/ready.
module result_collector #(
  parameter int RESULT_W = 16,
  parameter int OP_W     = 4,
  parameter int TAG_W    = 2,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  result_collector_if.slave bus
);
  localparam int NTAG  = 2**TAG_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [OP_W-1:0] RESET_OP = OP_W'(1);

  logic [RESULT_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]    tag_mem  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [NTAG-1:0]     sb;
  logic                err_unexp_q, err_ovf_q, err_dup_q;

  logic                hit, pop, full, push, is_set, is_clr, dup;
  logic [NTAG-1:0]     sb_next;

  always_comb begin
    hit    = bus.res_valid && sb[bus.res_tag];
    pop    = (count != '0) && bus.out_ready;
    full   = (count == CNT_W'(DEPTH));
    push   = hit && (!full || pop);
    is_set = bus.issue_valid && bus.issue_op[OP_W-1];
    is_clr = bus.issue_valid && (bus.issue_op == RESET_OP);
    // A result returning on the same tag in the same cycle frees it, so no dup.
    dup    = is_set && sb[bus.issue_tag] &&
             !(bus.res_valid && (bus.res_tag == bus.issue_tag));
    sb_next = sb;
    if (hit)    sb_next[bus.res_tag]   = 1'b0;
    if (is_set) sb_next[bus.issue_tag] = 1'b1;
    if (is_clr) sb_next = '0;
  end

  // Control state: pointers, occupancy, scoreboard and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sb          <= '0;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      sb          <= sb_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      err_unexp_q <= bus.res_valid && !sb[bus.res_tag];
      err_ovf_q   <= hit && !push;
      err_dup_q   <= dup;
    end
  end

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.res_data;
      tag_mem[wr_ptr]  <= bus.res_tag;
    end
  end

  // Head is gated by valid so the unreset storage never shows after reset.
  assign bus.out_valid      = (count != '0);
  assign bus.out_data       = bus.out_valid ? data_mem[rd_ptr] : '0;
  assign bus.out_tag        = bus.out_valid ? tag_mem[rd_ptr]  : '0;
  assign bus.fifo_count     = count;
  assign bus.outstanding    = sb;
  assign bus.err_unexpected = err_unexp_q;
  assign bus.err_overflow   = err_ovf_q;
  assign bus.err_dup_issue  = err_dup_q;
endmodule
